tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer: the receive-side counterpart of the lab 4-to-1 mux. It accepts one serialized word stream, where the transmitting mux cycles its select through slots 0..3, and redistributes each word onto one of four registered output channels `a`/`b`/`c`/`d`. Frame alignment uses a sync marker on slot 0. A one-cycle strobe marks each completed frame. It sits directly after the mux-based TDM link in the week-9 datapath.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_slot_cnt.sv | 29 ++
 rtl/tdm_demux4.sv | 116 +++++++++++
 tb/tb_tdm_demux4.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the four-channel TDM demultiplexer.
// Holds the slot count, slot encoding and alignment state enum.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_A,
        SLOT_B,
        SLOT_C,
        SLOT_D
    } slot_t;

    typedef enum logic {
        IDLE,
        RUN
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Two-bit wrapping slot counter for the TDM demultiplexer.
// Ports: clk, rst (sync, active-high), i_load (jump to slot 1),
//        i_inc (advance one slot, 3 wraps to 0), o_slot (next slot to fill).
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_inc,
    output slot_t o_slot
);

    slot_t r_slot;

    // A sync word occupies slot 0 itself, so the next word is slot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= SLOT_A;
        end else if (i_load) begin
            r_slot <= SLOT_B;
        end else if (i_inc) begin
            r_slot <= slot_t'(r_slot + 2'd1);
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with slot-0 sync alignment.
// Ports: clk, rst (sync, active-high), din/din_valid/sync in;
//        a..d channel words, s1/s0 slot index, frame_valid/frame_err pulses.
// Build option: TDM_DEMUX_FRAME_BUF_EN selects double-buffered channels;
//        without it each accepted word writes its channel directly.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             s1,
    output logic             s0,
    output logic             frame_valid,
    output logic             frame_err
);

    tdm_state_t       r_state;
    logic [WIDTH-1:0] r_ch [NUM_SLOTS];
    logic             r_frame_valid;
    logic             r_frame_err;

`ifdef TDM_DEMUX_FRAME_BUF_EN
    // Slot 3 needs no buffer: it is published straight from din.
    logic [WIDTH-1:0] r_buf_a;
    logic [WIDTH-1:0] r_buf_b;
    logic [WIDTH-1:0] r_buf_c;
`endif

    slot_t w_slot;
    slot_t w_slot_eff;
    logic  w_take;
    logic  w_load;
    logic  w_inc;
    logic  w_done;
    logic  w_err;

    // In IDLE only a sync word is accepted; in RUN every valid word is.
    assign w_take     = din_valid && (sync || (r_state == RUN));
    assign w_load     = w_take && sync;
    assign w_inc      = w_take && !sync;
    // A sync word always lands in slot 0, realigning the frame.
    assign w_slot_eff = sync ? SLOT_A : w_slot;
    assign w_done     = w_inc && (w_slot == SLOT_D);
    assign w_err      = w_load && (r_state == RUN) && (w_slot != SLOT_A);

    tdm_slot_cnt u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_inc  (w_inc),
        .o_slot (w_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_ch[i] <= '0;
            end
`ifdef TDM_DEMUX_FRAME_BUF_EN
            r_buf_a <= '0;
            r_buf_b <= '0;
            r_buf_c <= '0;
`endif
        end else begin
            r_frame_valid <= w_done;
            r_frame_err   <= w_err;
            if (w_take) begin
                r_state <= RUN;
            end
`ifdef TDM_DEMUX_FRAME_BUF_EN
            // Stale slot 1/2 data after a misalignment is always
            // overwritten before the next publish, so no clear needed.
            if (w_take) begin
                case (w_slot_eff)
                    SLOT_A:  r_buf_a <= din;
                    SLOT_B:  r_buf_b <= din;
                    SLOT_C:  r_buf_c <= din;
                    default: ;
                endcase
            end
            if (w_done) begin
                r_ch[0] <= r_buf_a;
                r_ch[1] <= r_buf_b;
                r_ch[2] <= r_buf_c;
                r_ch[3] <= din;
            end
`else
            if (w_take) begin
                r_ch[w_slot_eff] <= din;
            end
`endif
        end
    end

    assign a           = r_ch[0];
    assign b           = r_ch[1];
    assign c           = r_ch[2];
    assign d           = r_ch[3];
    assign s1          = w_slot[1];
    assign s0          = w_slot[0];
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=8).
// Expectations follow the TDM_DEMUX_FRAME_BUF_EN build setting.
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       sync;
    logic [7:0] a, b, c, d;
    logic       s1, s0;
    logic       frame_valid;
    logic       frame_err;

    int checks;
    int errors;

`ifdef TDM_DEMUX_FRAME_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic s);
        din       = w;
        sync      = s;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 8'h00;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({a, b, c, d} !== 32'h0) begin
            errors++;
            $display("FAIL reset_ch got %h want 00000000", {a, b, c, d});
        end
        checks++;
        if ({s1, s0, frame_valid, frame_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {s1, s0, frame_valid, frame_err});
        end
    endtask

    task automatic test_frame();
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_early_fv got %b want 0", frame_valid);
        end
        send(8'h44, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || {a, b, c, d} !== 32'h11223344) begin
            errors++;
            $display("FAIL frame_pub got fv=%b %h want fv=1 11223344",
                     frame_valid, {a, b, c, d});
        end
        step();
        checks++;
        if (frame_valid !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL frame_fv_drop got fv=%b s=%b want fv=0 s=00",
                     frame_valid, {s1, s0});
        end
    endtask

    task automatic test_discard();
        test_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        checks++;
        if ({s1, s0} !== 2'b00 || {a, b, c, d} !== 32'h0) begin
            errors++;
            $display("FAIL idle_discard got s=%b ch=%h want s=00 ch=0",
                     {s1, s0}, {a, b, c, d});
        end
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || {a, b, c, d} !== 32'h01020304) begin
            errors++;
            $display("FAIL discard_pub got fv=%b %h want fv=1 01020304",
                     frame_valid, {a, b, c, d});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] words [4];
        logic [7:0] exp_a;
        words[0] = 8'h05; words[1] = 8'h06;
        words[2] = 8'h07; words[3] = 8'h08;
        for (int w = 0; w < 4; w++) begin
            send(words[w], (w == 0));
            for (int g = 0; g < 3; g++) begin
                // sync without din_valid must be ignored
                sync = 1'b1;
                step();
                sync = 1'b0;
                checks++;
                if ({s1, s0} !== 2'((w + 1) % 4) || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold w%0d g%0d got s=%b fe=%b want s=%0d fe=0",
                             w, g, {s1, s0}, frame_err, (w + 1) % 4);
                end
            end
            if (w == 0) begin
                exp_a = BUF ? 8'h01 : 8'h05;
                checks++;
                if (a !== exp_a) begin
                    errors++;
                    $display("FAIL gap_a_mid got %h want %h", a, exp_a);
                end
            end
        end
        checks++;
        if ({a, b, c, d} !== 32'h05060708) begin
            errors++;
            $display("FAIL gap_pub got %h want 05060708", {a, b, c, d});
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_ch;
        send(8'h10, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_first_fe got %b want 0", frame_err);
        end
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        exp_ch = BUF ? 32'h05060708 : 32'h30200708;
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0 || {s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL mis_err got fe=%b fv=%b s=%b want fe=1 fv=0 s=01",
                     frame_err, frame_valid, {s1, s0});
        end
        checks++;
        if ({a, b, c, d} !== exp_ch) begin
            errors++;
            $display("FAIL mis_hold got %h want %h", {a, b, c, d}, exp_ch);
        end
        send(8'h40, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_fe_drop got %b want 0", frame_err);
        end
        send(8'h50, 1'b0);
        send(8'h60, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || {a, b, c, d} !== 32'h30405060) begin
            errors++;
            $display("FAIL mis_pub got fv=%b %h want fv=1 30405060",
                     frame_valid, {a, b, c, d});
        end
        step();
    endtask

    task automatic test_reset_mid();
        send(8'h77, 1'b1);
        send(8'h88, 1'b0);
        rst = 1'b1; din = 8'h99; din_valid = 1'b1; sync = 1'b0;
        step();
        rst = 1'b0; din_valid = 1'b0;
        checks++;
        if ({a, b, c, d} !== 32'h0 || {s1, s0, frame_valid, frame_err} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid got ch=%h ctl=%b want 0",
                     {a, b, c, d}, {s1, s0, frame_valid, frame_err});
        end
        send(8'h99, 1'b0);
        checks++;
        if ({s1, s0} !== 2'b00 || a !== 8'h00) begin
            errors++;
            $display("FAIL rst_idle got s=%b a=%h want s=00 a=00", {s1, s0}, a);
        end
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        rst = 1'b1; din = 8'h04; din_valid = 1'b1;
        step();
        rst = 1'b0; din_valid = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || {a, b, c, d} !== 32'h0) begin
            errors++;
            $display("FAIL rst_kill got fv=%b ch=%h want fv=0 ch=0",
                     frame_valid, {a, b, c, d});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            din       = 8'h40 + 8'(k);
            sync      = ((k % 4) == 0);
            din_valid = 1'b1;
            step();
            checks++;
            if (frame_valid !== ((k % 4) == 3) || {s1, s0} !== 2'((k + 1) % 4)) begin
                errors++;
                $display("FAIL b2b k%0d got fv=%b s=%b want fv=%b s=%0d",
                         k, frame_valid, {s1, s0}, ((k % 4) == 3), (k + 1) % 4);
            end
        end
        din_valid = 1'b0;
        sync      = 1'b0;
        checks++;
        if ({a, b, c, d} !== 32'h48494A4B) begin
            errors++;
            $display("FAIL b2b_pub got %h want 48494a4b", {a, b, c, d});
        end
        step();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fv_drop got %b want 0", frame_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_frame();
        test_discard();
        test_gaps();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
